// File: rtl/usb4_rx_pkg.sv
// Shared definitions for the USB4 receive-side lane deserializer:
// generation codes, per-generation frame lengths and the lookup between them.
package usb4_rx_pkg;

  typedef enum logic [1:0] {
    GEN4     = 2'b00,
    GEN3     = 2'b01,
    GEN2     = 2'b10,
    GEN_RSVD = 2'b11
  } gen_e;

  localparam int FL_GEN4 = 8;
  localparam int FL_GEN3 = 132;
  localparam int FL_GEN2 = 66;

  // The reserved code falls through to the Gen4 length.
  function automatic int unsigned frame_len(input gen_e gen);
    case (gen)
      GEN3:    return FL_GEN3;
      GEN2:    return FL_GEN2;
      default: return FL_GEN4;
    endcase
  endfunction

endpackage

// File: rtl/lanes_deserializer_mx_if.sv
// Bus between the lane PHY serial side (master) and the deserializer (slave).
interface lanes_deserializer_mx_if #(
  parameter int WIDTH     = 132,
  parameter int NUM_LANES = 2
);
  logic                       enable_deser;
  logic [1:0]                 gen_speed;
  logic [NUM_LANES-1:0]       lane_rx_ser;
  logic                       bit_slip;
  logic [NUM_LANES*WIDTH-1:0] lane_rx_parallel;
  logic                       frame_valid;
  logic                       slip_ack;
  logic                       descr_rst;
  logic                       enable_dec;

  // No back-pressure: frame_valid and slip_ack are one-cycle pulses that the
  // consumer must take when high; lane_rx_parallel then holds until the next frame.
  modport master (
    output enable_deser, gen_speed, lane_rx_ser, bit_slip,
    input  lane_rx_parallel, frame_valid, slip_ack, descr_rst, enable_dec
  );

  modport slave (
    input  enable_deser, gen_speed, lane_rx_ser, bit_slip,
    output lane_rx_parallel, frame_valid, slip_ack, descr_rst, enable_dec
  );

endinterface

// File: rtl/lane_shift_reg.sv
// One lane: LSB-first serial shift register plus the captured parallel frame.
module lane_shift_reg #(
  parameter int WIDTH = 132,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             ser,
  input  logic             capture,
  input  logic [CW-1:0]    fl,
  output logic [WIDTH-1:0] par
);

  // The oldest bit shifts out before any capture can see it, so only
  // WIDTH-1 history bits are stored.
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt   = {ser, sh_q};
    sh_d  = clear ? '0 : nxt[WIDTH-1:1];
    par_d = par_q;
    if (clear) begin
      par_d = '0;
    end else if (capture) begin
      // Newest FL bits sit at the top of nxt; bring them down, zero-extended.
      par_d = nxt >> (CW'(WIDTH) - fl);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q  <= '0;
      par_q <= '0;
    end else begin
      sh_q  <= sh_d;
      par_q <= par_d;
    end
  end

  assign par = par_q;

endmodule

// File: rtl/lanes_deserializer_mx.sv
// Multi-lane USB4 receive deserializer: shared frame counter, bit-slip
// alignment and decoder-enable gating over NUM_LANES lane shift registers.
module lanes_deserializer_mx
  import usb4_rx_pkg::*;
#(
  parameter int WIDTH     = 132,
  parameter int NUM_LANES = 2
) (
  input logic                    clk,
  input logic                    rst,
  lanes_deserializer_mx_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gen_q, gen_d;
  logic          frm_seen_q, frm_seen_d;
  logic          frame_valid_q, frame_valid_d;
  logic          slip_ack_q, slip_ack_d;
  logic          enable_dec_q, enable_dec_d;

  logic [CW-1:0] fl;
  logic          clear, last, capture, slip_acc;
  logic [NUM_LANES*WIDTH-1:0] par_flat;

  always_comb begin
    fl       = CW'(frame_len(gen_e'(gen_q)));
    clear    = !bus.enable_deser || (bus.gen_speed != gen_q);
    last     = (cnt_q == fl - CW'(1));
    capture  = !clear && last;
    // A slip on the capture cycle would split a frame, so it is dropped there.
    slip_acc = !clear && bus.bit_slip && !last;

    gen_d         = clear ? bus.gen_speed : gen_q;
    frame_valid_d = capture;
    slip_ack_d    = slip_acc;
    cnt_d         = cnt_q;
    frm_seen_d    = frm_seen_q;
    enable_dec_d  = enable_dec_q;

    if (clear) begin
      cnt_d        = '0;
      frm_seen_d   = 1'b0;
      enable_dec_d = 1'b0;
    end else if (slip_acc) begin
      frm_seen_d   = 1'b0;
      enable_dec_d = 1'b0;
    end else if (last) begin
      cnt_d        = '0;
      enable_dec_d = frm_seen_q;
      frm_seen_d   = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      gen_q         <= bus.gen_speed;
      frm_seen_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      slip_ack_q    <= 1'b0;
      enable_dec_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      gen_q         <= gen_d;
      frm_seen_q    <= frm_seen_d;
      frame_valid_q <= frame_valid_d;
      slip_ack_q    <= slip_ack_d;
      enable_dec_q  <= enable_dec_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_shift_reg #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .ser     (bus.lane_rx_ser[i]),
      .capture (capture),
      .fl      (fl),
      .par     (par_flat[i*WIDTH +: WIDTH])
    );
  end

  assign bus.lane_rx_parallel = par_flat;
  assign bus.frame_valid      = frame_valid_q;
  assign bus.slip_ack         = slip_ack_q;
  assign bus.enable_dec       = enable_dec_q;
  assign bus.descr_rst        = !clear && (cnt_q == fl - CW'(2));

endmodule

// File: tb/tb_lanes_deserializer_mx.sv
// Directed bench for lanes_deserializer_mx: hand-computed frames per generation,
// slip, speed change, reset and disable mid-frame.
module tb_lanes_deserializer_mx;
  import usb4_rx_pkg::*;

  localparam int WIDTH     = 132;
  localparam int NUM_LANES = 2;
  localparam int BW        = NUM_LANES * WIDTH;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   fv_cnt = 0;
  int   sa_cnt = 0;
  int   fv0;
  logic [BW-1:0] exp_q[$];

  lanes_deserializer_mx_if #(.WIDTH(WIDTH), .NUM_LANES(NUM_LANES)) bus();

  lanes_deserializer_mx #(.WIDTH(WIDTH), .NUM_LANES(NUM_LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.slip_ack) sa_cnt++;
    if (bus.frame_valid) begin
      fv_cnt++;
      if (exp_q.size() == 0) check("spurious_frame", BW'(bus.frame_valid), BW'(0));
      else                   check("frame_data", bus.lane_rx_parallel, exp_q.pop_front());
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "/par"},        bus.lane_rx_parallel,    BW'(0));
    check({tag, "/fv"},         BW'(bus.frame_valid),    BW'(0));
    check({tag, "/slip_ack"},   BW'(bus.slip_ack),       BW'(0));
    check({tag, "/enable_dec"}, BW'(bus.enable_dec),     BW'(0));
    check({tag, "/descr_rst"},  BW'(bus.descr_rst),      BW'(0));
  endtask

  // ---------------- drivers ----------------
  task automatic send_bits(input int n, input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1);
    for (int b = 0; b < n; b++) begin
      bus.lane_rx_ser = {s1[b], s0[b]};
      tick();
    end
  endtask

  // Sends one frame starting at a frame boundary; an accepted slip adds one bit.
  task automatic send_frame(input string tag, input int fl,
                            input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                            input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                            input logic exp_dec, input int slip_at, input logic exp_ack);
    int fv_s, sa_s, dr_bad, ecnt, n;
    fv_s   = fv_cnt;
    sa_s   = sa_cnt;
    dr_bad = 0;
    ecnt   = 0;
    n      = exp_ack ? fl + 1 : fl;
    exp_q.push_back({e1, e0});
    for (int b = 0; b < n; b++) begin
      if (bus.descr_rst !== (ecnt == fl - 2)) dr_bad++;
      bus.lane_rx_ser = {s1[b], s0[b]};
      bus.bit_slip    = (b == slip_at);
      tick();
      bus.bit_slip = 1'b0;
      if (b == slip_at && exp_ack) begin
        check({tag, "/slip_ack"}, BW'(bus.slip_ack),   BW'(1));
        check({tag, "/dec_drop"}, BW'(bus.enable_dec), BW'(0));
      end else begin
        ecnt++;
      end
    end
    check({tag, "/fv"},        BW'(bus.frame_valid),  BW'(1));
    check({tag, "/nframes"},   BW'(fv_cnt - fv_s),    BW'(1));
    check({tag, "/slips"},     BW'(sa_cnt - sa_s),    BW'(exp_ack));
    check({tag, "/dec"},       BW'(bus.enable_dec),   BW'(exp_dec));
    check({tag, "/descr_rst"}, BW'(dr_bad),           BW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst              = 1'b0;
    bus.enable_deser = 1'b1;
    bus.gen_speed    = GEN4;
    bus.lane_rx_ser  = '0;
    bus.bit_slip     = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b1;

    // Gen4: 0xA5 on lane0 from the first enabled cycle
    send_frame("g4_first",  FL_GEN4, 132'hA5, 132'h3C, 132'hA5, 132'h3C, 1'b0, -1, 1'b0);
    send_frame("g4_second", FL_GEN4, 132'h5A, 132'hC3, 132'h5A, 132'hC3, 1'b1, -1, 1'b0);
    bus.lane_rx_ser = 2'b11;
    tick();
    check("hold_fv",  BW'(bus.frame_valid), BW'(0));
    check("hold_par", bus.lane_rx_parallel, {132'hC3, 132'h5A});

    // Gen3: two full 132-bit frames
    bus.gen_speed = GEN3;
    tick();
    check_idle("to_g3");
    send_frame("g3_a", FL_GEN3,
               132'hF0123456789ABCDEFFEDCBA9876543210, 132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0,
               132'hF0123456789ABCDEFFEDCBA9876543210, 132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0,
               1'b0, -1, 1'b0);
    send_frame("g3_b", FL_GEN3,
               132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0, 132'hF0123456789ABCDEFFEDCBA9876543210,
               132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0, 132'hF0123456789ABCDEFFEDCBA9876543210,
               1'b1, -1, 1'b0);

    // Gen2 with bit slip
    bus.gen_speed = GEN2;
    tick();
    check_idle("to_g2");
    send_frame("g2_a", FL_GEN2, 132'h111112222333344444, 132'h2AAAABBBBCCCCDDDD,
               132'h111112222333344444 & 132'h3FFFFFFFFFFFFFFFF, 132'h2AAAABBBBCCCCDDDD,
               1'b0, -1, 1'b0);
    send_frame("g2_b", FL_GEN2, 132'h00F0F1E1E2D2D3C3C, 132'h38877665544332211,
               132'h00F0F1E1E2D2D3C3C, 132'h38877665544332211, 1'b1, -1, 1'b0);
    // slip at cnt=10: frame spans 67 bits, oldest bit dropped
    send_frame("g2_slip", FL_GEN2,
               {65'd0, 66'h2DEADBEEFCAFEF00D, 1'b1}, {65'd0, 66'h10123456789ABCDEF, 1'b0},
               132'h2DEADBEEFCAFEF00D, 132'h10123456789ABCDEF, 1'b0, 10, 1'b1);
    send_frame("g2_after", FL_GEN2, 132'h05555666677778888, 132'h19999AAAABBBBCCCC,
               132'h05555666677778888, 132'h19999AAAABBBBCCCC, 1'b1, -1, 1'b0);
    // slip on the capture cycle is dropped
    send_frame("g2_late_slip", FL_GEN2, 132'h30000111100001111, 132'h2FFFFEEEEDDDDCCCC,
               132'h30000111100001111, 132'h2FFFFEEEEDDDDCCCC, 1'b1, 65, 1'b0);

    // Gen4 -> Gen2 change mid-frame at cnt=5
    bus.gen_speed = GEN4;
    tick();
    send_frame("g4_c", FL_GEN4, 132'h96, 132'h69, 132'h96, 132'h69, 1'b0, -1, 1'b0);
    send_frame("g4_d", FL_GEN4, 132'h0F, 132'hF0, 132'h0F, 132'hF0, 1'b1, -1, 1'b0);
    fv0 = fv_cnt;
    send_bits(5, 132'h1F, 132'h1F);
    check("pre_switch_dec", BW'(bus.enable_dec), BW'(1));
    bus.gen_speed = GEN2;
    tick();
    check_idle("g4_to_g2");
    check("g4_to_g2/nframes", BW'(fv_cnt - fv0), BW'(0));
    send_frame("g2_first", FL_GEN2, 132'h2468013579BDFACE0, 132'h1FEDC000012345678,
               132'h2468013579BDFACE0, 132'h1FEDC000012345678, 1'b0, -1, 1'b0);

    // Gen3 reset mid-frame at cnt=60, then disable mid-frame
    bus.gen_speed = GEN3;
    tick();
    send_frame("g3_c", FL_GEN3,
               132'hF0123456789ABCDEFFEDCBA9876543210, 132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0,
               132'hF0123456789ABCDEFFEDCBA9876543210, 132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0,
               1'b0, -1, 1'b0);
    fv0 = fv_cnt;
    send_bits(60, 132'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 132'h123456789ABCDEF);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_idle("rst_mid");
    check("rst_mid/nframes", BW'(fv_cnt - fv0), BW'(0));
    send_frame("g3_d", FL_GEN3,
               132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0, 132'hF0123456789ABCDEFFEDCBA9876543210,
               132'hA5555AAAA3333CCCC0F0F0F0FF0F0F0F0, 132'hF0123456789ABCDEFFEDCBA9876543210,
               1'b0, -1, 1'b0);
    fv0 = fv_cnt;
    send_bits(60, 132'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 132'h123456789ABCDEF);
    bus.enable_deser = 1'b0;
    tick();
    check_idle("dis_mid");
    check("dis_mid/nframes", BW'(fv_cnt - fv0), BW'(0));
    bus.enable_deser = 1'b1;

    // gen_speed=11 behaves as Gen4
    bus.gen_speed = 2'b11;
    tick();
    check_idle("to_g11");
    send_frame("g11_first",  FL_GEN4, 132'hA5, 132'h3C, 132'hA5, 132'h3C, 1'b0, -1, 1'b0);
    send_frame("g11_second", FL_GEN4, 132'h5A, 132'hC3, 132'h5A, 132'hC3, 1'b1, -1, 1'b0);

    // ---------------- report ----------------
    check("exp_q_empty", BW'(exp_q.size()), BW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
